// File: rtl/seg_pkg.sv
// Shared constants and FSM state type for the seven-segment scan driver.
package seg_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic {
    GUARD,
    ACTIVE
  } state_t;

  // Explicit minus for users that want one; codes 10..15 all render as a dash.
  localparam logic [BCD_W-1:0] DASH = 4'hA;

endpackage

// File: rtl/seg_scan_if.sv
// Value-source / display-side bundle for seg_scan.
interface seg_scan_if
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS = 4
);

  logic                      load;
  logic [BCD_W*DIGITS-1:0]   bcd_in;
  logic [DIGITS-1:0]         dp_in;
  logic [BCD_W-1:0]          num;
  logic [DIGITS-1:0]         dig_sel;
  logic                      dp;

  modport master (
    output load, bcd_in, dp_in,
    input  num, dig_sel, dp
  );

  modport slave (
    input  load, bcd_in, dp_in,
    output num, dig_sel, dp
  );

endinterface

// File: rtl/seg_scan_timer.sv
// Reloadable down-counter pacing the GUARD/ACTIVE phases of seg_scan.
module scan_timer #(
  parameter int unsigned     W    = 8,
  parameter logic [W-1:0]    INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         reload,
  input  logic [W-1:0] value,
  output logic         terminal
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= INIT;
    end else if (reload) begin
      count <= value;
    end else begin
      count <= count - 1'b1;
    end
  end

  assign terminal = (count == '0);

endmodule

// File: rtl/seg_scan.sv
// Multiplexed N-digit seven-segment scan driver with inter-digit guard time.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000,
  parameter int unsigned GUARD  = 16
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned CNT_W = $clog2((DIV > GUARD) ? DIV : GUARD);

  state_t                        state;
  logic [IDX_W-1:0]              idx;
  logic [DIGITS-1:0][BCD_W-1:0]  sh_bcd;
  logic [DIGITS-1:0]             sh_dp;
  logic [BCD_W-1:0]              num_r;
  logic [DIGITS-1:0]             sel_r;
  logic                          dp_r;

  logic                          terminal;
  logic [CNT_W-1:0]              reload_val;
  logic [DIGITS-1:0]             sel_idx;
  logic                          blank;

  // Every state change happens on terminal, so the timer reloads exactly then.
  scan_timer #(
    .W    (CNT_W),
    .INIT (CNT_W'(GUARD - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .reload   (terminal),
    .value    (reload_val),
    .terminal (terminal)
  );

  always_comb begin
    reload_val = (state == seg_pkg::GUARD) ? CNT_W'(DIV - 1) : CNT_W'(GUARD - 1);
  end

  always_comb begin
    sel_idx      = '0;
    sel_idx[idx] = 1'b1;
  end

`ifdef SEG_SCAN_LZB_EN
  // Blank when this digit and all more-significant digits are zero; digit 0 always shows.
  always_comb begin
    blank = (idx != '0);
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if ((k >= 32'(idx)) && (sh_bcd[k] != '0)) begin
        blank = 1'b0;
      end
    end
  end
`else
  always_comb begin
    blank = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= seg_pkg::GUARD;
      idx    <= '0;
      sh_bcd <= '0;
      sh_dp  <= '0;
      num_r  <= '0;
      sel_r  <= '0;
      dp_r   <= 1'b0;
    end else begin
      if (bus.load) begin
        sh_bcd <= bus.bcd_in;
        sh_dp  <= bus.dp_in;
      end
      if (terminal) begin
        if (state == seg_pkg::GUARD) begin
          state <= seg_pkg::ACTIVE;
          num_r <= sh_bcd[idx];
          dp_r  <= sh_dp[idx] & ~blank;
          sel_r <= blank ? '0 : sel_idx;
        end else begin
          state <= seg_pkg::GUARD;
          sel_r <= '0;
          idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end
      end
    end
  end

  assign bus.num     = num_r;
  assign bus.dig_sel = sel_r;
  assign bus.dp      = dp_r;

endmodule

// File: tb/tb_seg_scan.sv
// Randomized self-checking bench for seg_scan against a time-based reference model.
module tb_seg_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int GUARD  = 2;
  localparam int SLOT   = DIV + GUARD;

  logic clk = 1'b0;
  logic rst;

  seg_scan_if #(.DIGITS(DIGITS)) bus ();

  seg_scan #(
    .DIGITS (DIGITS),
    .DIV    (DIV),
    .GUARD  (GUARD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference state: edges since the reset edge, shadow copy, expected outputs.
  int                e;
  logic [3:0]        msh [DIGITS];
  logic [DIGITS-1:0] mshdp;
  logic [3:0]        m_num;
  logic [DIGITS-1:0] m_sel;
  logic              m_dp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
  endtask

  function automatic logic lead_blank(input int d);
`ifdef SEG_SCAN_LZB_EN
    if (d == 0) return 1'b0;
    for (int k = d; k < DIGITS; k++) if (msh[k] != 4'd0) return 1'b0;
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  // Slot n starts GUARD + n*SLOT edges after reset and lights for DIV edges.
  task automatic model_edge(input logic r, input logic ld, input logic [15:0] b,
                            input logic [3:0] dpi);
    int p;
    int d;
    if (r) begin
      e = 0;
      for (int k = 0; k < DIGITS; k++) msh[k] = 4'd0;
      mshdp = '0;
      m_num = 4'd0;
      m_sel = '0;
      m_dp  = 1'b0;
    end else begin
      e++;
      p = e - GUARD;
      if (p >= 0 && (p % SLOT) == 0) begin
        d     = (p / SLOT) % DIGITS;
        m_num = msh[d];
        m_dp  = mshdp[d] && !lead_blank(d);
        m_sel = lead_blank(d) ? '0 : (DIGITS'(1) << d);
      end else if (p >= 0 && (p % SLOT) == DIV) begin
        m_sel = '0;
      end
      if (ld) begin
        for (int k = 0; k < DIGITS; k++) msh[k] = b[4*k +: 4];
        mshdp = dpi;
      end
    end
  endtask

  task automatic tick(input string tag, input logic r, input logic ld,
                      input logic [15:0] b, input logic [3:0] dpi);
    rst        = r;
    bus.load   = ld;
    bus.bcd_in = b;
    bus.dp_in  = dpi;
    @(posedge clk);
    model_edge(r, ld, b, dpi);
    @(negedge clk);
    check({tag, ".num"},     32'(bus.num),     32'(m_num));
    check({tag, ".dig_sel"}, 32'(bus.dig_sel), 32'(m_sel));
    check({tag, ".dp"},      32'(bus.dp),      32'(m_dp));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 1'b0, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  initial begin
    logic [31:0] rb;
    logic        found;
    int          k;

    // Reset then idle: one full frame and a wrap.
    tick("reset", 1'b1, 1'b0, 16'h0, 4'h0);
    tick("reset", 1'b1, 1'b0, 16'h0, 4'h0);
    check("reset_sel_const", 32'(bus.dig_sel), 32'h0);
    check("reset_num_const", 32'(bus.num), 32'h0);
    idle("idle", 30);

    // Ordinary load and two frames of display.
    tick("load1234", 1'b0, 1'b1, 16'h1234, 4'b0100);
    idle("frame1234", 2 * SLOT * DIGITS);

    // Load pulse landing on the exact slot-start edge.
    for (int i = 0; i < SLOT && ((e + 1 - GUARD) % SLOT) != 0; i++) idle("align", 1);
    tick("load_at_start", 1'b0, 1'b1, 16'h9876, 4'b1011);
    idle("after_start", 2 * SLOT);

    // Reset in the middle of digit 2's active phase.
    found = 1'b0;
    for (int i = 0; i < 3 * SLOT * DIGITS && !found; i++) begin
      idle("seek_d2", 1);
      found = (m_sel == 4'b0100) && (((e - GUARD) % SLOT) == 1);
    end
    check("find_digit2", 32'(found), 32'h1);
    tick("rst_mid", 1'b1, 1'b0, 16'h0, 4'h0);
    check("rst_mid_sel_const", 32'(bus.dig_sel), 32'h0);
    idle("restart", SLOT * DIGITS + 4);

    // Non-decimal code passes through.
    tick("loadC5", 1'b0, 1'b1, 16'h00C5, 4'h0);
    idle("frameC5", 2 * SLOT * DIGITS);

    // Leading-zero cases (blanked only when the feature is built in).
    tick("load0005", 1'b0, 1'b1, 16'h0005, 4'b1111);
    idle("frame0005", 2 * SLOT * DIGITS);
    tick("load0000", 1'b0, 1'b1, 16'h0000, 4'b1111);
    idle("frame0000", 2 * SLOT * DIGITS);

    // Random loads with varying numbers of leading zeros and rare resets.
    for (int i = 0; i < 400; i++) begin
      k  = int'($urandom_range(0, 4));
      rb = $urandom & ((k == 4) ? 32'hFFFF : ((32'h1 << (4 * k)) - 1));
      tick("rand", ($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0),
           rb[15:0], 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed scan driver for an N-digit common-select seven-segment display. It latches a packed BCD word and time-multiplexes the digits one at a time onto a single 4-bit `num` bus, which feeds the seven-segment decoder directly downstream. It drives one-hot digit selects and a decimal point, with a guard interval between digits to suppress ghosting. It sits between the application's BCD value source and the decoder/pin drivers.

## Interface
- `DIGITS`, 4: number of display digits (2..8).
- `DIV`, 50000: clock cycles each digit stays lit (ACTIVE phase), ≥2.
- `GUARD`, 16: clock cycles all selects stay off between digits, ≥1.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `load` input 1: a one-cycle pulse captures `bcd_in`/`dp_in` into the shadow register.
- `bcd_in` input 4*DIGITS: packed BCD; digit k = `bcd_in[4k+3:4k]`; digit 0 is rightmost.
- `dp_in` input DIGITS: decimal point per digit.
- `num` output 4: current digit code to the decoder.
- `dig_sel` output DIGITS: one-hot active-high digit enable; all-zero when dark.
- `dp` output 1: decimal point for the lit digit.

## Operation
- Shadow register (`sh_bcd`, `sh_dp`) loads on `load`=1; it holds otherwise. Codes 10–15 pass through unchanged (the decoder shows a dash).
- Display register: at the start of every ACTIVE slot, digit `idx` is copied from the shadow into `num`/`dp`. A `load` never alters a slot already in progress.
- FSM with 2 states:
  - GUARD: `dig_sel`=0 for GUARD cycles. On the last cycle, go to ACTIVE and present digit `idx`.
  - ACTIVE: `dig_sel[idx]`=1 for DIV cycles. On the last cycle, go to GUARD and set `idx` to (`idx`+1) mod DIGITS, wrapping DIGITS-1 → 0.
- Phase counter width is clog2(max(DIV,GUARD)). It counts down and reloads on every state change.
- `load` coinciding with a slot start: the slot shows the **old** shadow value. The new value is first visible at the next slot.
- Reset in mid-slot: all state is cleared on the next edge, with no partial slot completed.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset values: `num`=0, `dig_sel`=0, `dp`=0, state=GUARD, `idx`=0, counter=GUARD-1, shadow=0.
- After `rst` deasserts, `dig_sel[0]` first rises GUARD cycles later.
- Slot period is DIV+GUARD cycles. A full frame is DIGITS·(DIV+GUARD) cycles.
- `num`/`dp` change on the same edge as `dig_sel` rises. They hold through the following GUARD phase.
- `load` to visibility on digit k: at most one frame plus GUARD cycles.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking.
  - At each slot start, a digit is treated as blank if its shadow code is 0 and every higher-index digit's code is 0.
  - Digit 0 is never blanked.
  - A blanked slot keeps its full DIV timing, with `dig_sel`=0 and `dp`=`dp_in` bit not shown (`dp`=0).
- Undefined: every digit is always lit; no blanking logic is synthesized.

## Structure
- Shared package `seg_pkg`:
  - BCD width constant (4).
  - FSM state typedef {GUARD, ACTIVE}.
  - Dash code constant (4'hA) for users that need an explicit minus.
- One sub-module, `scan_timer`:
  - Reloadable down-counter with `terminal` output.
  - Parameterised by width.
  - The FSM drives its reload value (DIV-1 or GUARD-1).

## Test plan
Common bench setup: DIGITS=4, DIV=4, GUARD=2.
- Reset then idle: `dig_sel` is 0 for 2 cycles, then 0001, 0000 ×2, 0010 … wrapping to 0001 after 24 cycles. `num`=0 throughout.
- `load` with `bcd_in`=16'h1234, `dp_in`=4'b0100: the next frame shows `num`=4,3,2,1 with `dig_sel`=0001,0010,0100,1000. `dp`=1 only in the slot with `dig_sel`=0100.
- `load` pulse on the exact cycle a slot starts: that slot keeps the old code; the following slot shows the new code.
- `rst` asserted mid-ACTIVE on digit 2: the next edge gives `dig_sel`=0, `num`=0, and the restart is at digit 0.
- `bcd_in`=16'h00C5: code 12 appears on `num` for digit 1 (pass-through); no other effect.
- With `SEG_SCAN_LZB_EN`, `bcd_in`=16'h0005:
  - Digits 3, 2 and 1 have `dig_sel`=0 and `dp`=0 for their full slots.
  - Digit 0 lights with `num`=5.
  - With 16'h0000, only digit 0 lights, showing 0.
